// File: rtl/board_pkg.sv
// Shared defaults, state/grant types and the cell-index helper for the board RAM arbiter.
package board_pkg;

    localparam int COLS_DEF = 10;
    localparam int ROWS_DEF = 20;
    localparam int CELLS = COLS_DEF * ROWS_DEF;
    localparam logic [7:0] BG_COLOR_DEF = 8'h00;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } board_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        VGA  = 2'd1,
        PICO = 2'd2,
        CLR  = 2'd3
    } grant_e;

    // Ten-wide boards avoid a multiplier: r*10 = (r<<3)+(r<<1).
    function automatic logic [7:0] cell_index(input logic [7:0] row, input logic [7:0] col,
                                              input int cols);
        if (cols == 10)
            return (row << 3) + (row << 1) + col;
        else
            return row * 8'(cols) + col;
    endfunction

endpackage

// File: rtl/board_ram.sv
// Single-port 256x8 board memory: synchronous write-first read, one-cycle latency.
module board_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// Shares the board RAM between VGA cell fetches, PicoBlaze accesses and an optional clear sweep.
// Define BOARD_CLEAR_EN to build the CLEAR state, sweep counter and clear_done pulse.
module board_ram_arbiter
    import board_pkg::*;
#(
    parameter int         COLS     = COLS_DEF,
    parameter int         ROWS     = ROWS_DEF,
    parameter int         X0       = 15,
    parameter int         Y0       = 5,
    parameter logic [7:0] BG_COLOR = BG_COLOR_DEF,
    parameter int         MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ptick,
    input  logic [5:0] x_div,
    input  logic [5:0] y_div,
    output logic [7:0] vga_out,
    input  logic       pico_req,
    input  logic       pico_we,
    input  logic [7:0] pico_addr,
    input  logic [7:0] pico_data_in,
    output logic [7:0] pico_data_out,
    output logic       pico_ack,
    output logic       pico_busy,
    input  logic       clear_req,
    output logic       clear_done
);

    localparam logic [7:0] X_LO     = 8'(X0);
    localparam logic [7:0] X_HI     = 8'(X0 + COLS);
    localparam logic [7:0] Y_LO     = 8'(Y0);
    localparam logic [7:0] Y_HI     = 8'(Y0 + ROWS);
    localparam logic [8:0] CELLS_N  = 9'(COLS * ROWS);
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [7:0] x_ext, y_ext, vga_addr;
    logic       in_win, vga_fetch, vga_bg;
    logic       pend_vld, pend_we, pend_oob;
    logic [7:0] pend_addr, pend_data, wait_cnt;
    logic       clearing, pico_accept, override;
    grant_e     grant;
    logic       ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       vga_sel_p1, pdo_sel_p1, ack_p1;
    logic [7:0] vga_hold, pdo_hold;

    assign x_ext     = {2'b00, x_div};
    assign y_ext     = {2'b00, y_div};
    assign in_win    = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
    assign vga_fetch = ptick & in_win;
    assign vga_bg    = ptick & ~in_win;
    assign vga_addr  = cell_index(y_ext - Y_LO, x_ext - X_LO, COLS);

    assign pend_oob    = {1'b0, pend_addr} >= CELLS_N;
    assign pico_busy   = pend_vld | clearing;
    assign pico_accept = pico_req & ~pico_busy;
    assign override    = pend_vld && (wait_cnt == WAIT_MAX);

`ifdef BOARD_CLEAR_EN
    board_state_e state;
    logic [7:0]   cnt;
    logic         done_p1, cnt_last, clear_accept;

    assign clearing     = (state == CLEAR);
    assign cnt_last     = ({1'b0, cnt} == (CELLS_N - 9'd1));
    assign clear_accept = clear_req & ~pico_busy & ~pico_req;
    assign clear_done   = done_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            done_p1 <= 1'b0;
        end else begin
            done_p1 <= 1'b0;
            case (state)
                IDLE: if (clear_accept) begin
                    state <= CLEAR;
                    cnt   <= 8'd0;
                end
                CLEAR: if (grant == CLR) begin
                    if (cnt_last) begin
                        state   <= IDLE;
                        cnt     <= 8'd0;
                        done_p1 <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req;
    assign clearing         = 1'b0;
    assign clear_done       = 1'b0;
`endif

    // Reset blocks grants so an abandoned sweep or write never lands in the RAM.
    always_comb begin
        grant = NONE;
        if (rst)
            grant = NONE;
        else if (override)
            grant = PICO;
        else if (vga_fetch)
            grant = VGA;
        else if (pend_vld)
            grant = PICO;
        else if (clearing)
            grant = CLR;
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = vga_addr;
        ram_wdata = pend_data;
        case (grant)
            PICO: begin
                ram_addr = pend_addr;
                ram_we   = pend_we & ~pend_oob;
            end
`ifdef BOARD_CLEAR_EN
            CLR: begin
                ram_addr  = cnt;
                ram_wdata = 8'h00;
                ram_we    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    board_ram #(.DATA_W(8), .ADDR_W(8)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld <= 1'b0;
            wait_cnt <= 8'd0;
        end else if (grant == PICO) begin
            pend_vld <= 1'b0;
            wait_cnt <= 8'd0;
        end else if (pend_vld) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else if (pico_accept) begin
            pend_vld <= 1'b1;
            wait_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (pico_accept) begin
            pend_we   <= pico_we;
            pend_addr <= pico_addr;
            pend_data <= pico_data_in;
        end
    end

    // Stage p1: RAM read data appears; outputs select it or hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_sel_p1 <= 1'b0;
            pdo_sel_p1 <= 1'b0;
            ack_p1     <= 1'b0;
            vga_hold   <= BG_COLOR;
            pdo_hold   <= 8'h00;
        end else begin
            vga_sel_p1 <= (grant == VGA);
            pdo_sel_p1 <= (grant == PICO) && !pend_we && !pend_oob;
            ack_p1     <= (grant == PICO);
            vga_hold   <= vga_bg ? BG_COLOR : vga_out;
            pdo_hold   <= ((grant == PICO) && !pend_we && pend_oob) ? 8'h00 : pico_data_out;
        end
    end

    assign vga_out       = vga_sel_p1 ? ram_rdata : vga_hold;
    assign pico_data_out = pdo_sel_p1 ? ram_rdata : pdo_hold;
    assign pico_ack      = ack_p1;

endmodule
